writeback_unit: RTL and testbench
=================================

# writeback_unit

Final pipeline stage driving the register file write port (write_enable, write_reg, write_data). Merges single-cycle ALU results with in-order, variable-latency load data returned from memory. Sign- or zero-extends sub-word loads and keeps an in-order queue of outstanding loads. Publishes a per-register busy mask and a stall signal so decode can hold hazarding instructions.

## Interface
- LOAD_DEPTH, 2, number of outstanding loads the queue holds; legal range 1..4.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_reg  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- load_issue  input  1  load issued to memory this cycle; pushes a queue entry.
- load_issue_reg  input  5  load destination register.
- load_issue_type  input  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
- load_issue_offset  input  2  address bits [1:0] of the load.
- mem_rvalid  input  1  load data returned, strictly in issue order.
- mem_rdata  input  32  raw aligned memory word.
- write_enable  output  1  register file write strobe (registered).
- write_reg  output  5  register file write index (registered).
- write_data  output  32  register file write data (registered).
- busy_mask  output  32  bit i set while a load to register i is not yet retired; bit 0 always 0.
- stall  output  1  upstream must not assert alu_valid or load_issue while high.
- wb_error  output  1  sticky protocol-error flag.

## Operation
- State:
  - load queue of LOAD_DEPTH entries {reg, type, offset} with head/tail pointers and count;
  - one-entry ALU skid register {valid, reg, data};
  - output register {write_enable, write_reg, write_data, from_load}.
- Each cycle, pick at most one write source. Priority: load return (mem_rvalid with queue non-empty) > skid entry > live alu_valid.
- Conflicts with the ALU path:
  - If a load return and alu_valid coincide, the ALU result goes to the skid.
  - If the skid is occupied and alu_valid arrives, this is a protocol violation: set wb_error and drop the live ALU result.
- Load extension, using the head entry:
  - LB/LBU: select byte lane offset k = mem_rdata[8k+7:8k] (little-endian lanes); sign- or zero-extend to 32 bits.
  - LH/LHU: select halfword by offset[1] (0 gives [15:0], 1 gives [31:16]); offset[0] is ignored; sign- or zero-extend.
  - LW: mem_rdata unchanged.
- Register 0: any selected write with reg 0 is consumed normally (queue pops, skid drains), but write_enable stays 0. A load_issue to reg 0 still enqueues, so ordering is preserved.
- Queue:
  - load_issue pushes; a load return pops the head.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - mem_rvalid with an empty queue is ignored and sets wb_error.
  - load_issue while count==LOAD_DEPTH is dropped and sets wb_error.
- busy_mask (combinational from registers): OR of the decoded reg of every valid queue entry, plus write_reg when the output register holds a load write; bit 0 is forced to 0.
- stall (combinational from registers): skid valid OR count==LOAD_DEPTH.
- WAW rule: an ALU result targeting a register whose busy bit is set is a protocol violation. Decode prevents it; the block does not reorder.

## Timing
- Reset asserted: write_enable=0, write_reg=0, write_data=0, busy_mask=0, stall=0, wb_error=0. Queue and skid are emptied immediately, without waiting for clk.
- Reset mid-operation discards all outstanding loads and the skid. Returns that arrive after reset deasserts are errors (they set wb_error).
- ALU latency: alu_valid sampled at edge E; write_enable is high during the cycle after E; the register file captures at edge E+1.
- Load latency: mem_rvalid sampled at edge E; the extended data is on write_data during the next cycle.
- Skid drain: the skid writes in the first cycle without a load return, one cycle after it was filled at the earliest. stall falls in the cycle after the drain.
- Busy-bit timing: a busy bit rises in the cycle after load_issue is sampled. It falls in the cycle after the load's output-register cycle, i.e. when the register file already holds the value.
- The output register is loaded every cycle; write_enable=0 when no source is selected.

## Test plan
- ALU only: alu_valid=1, reg 5, data 0x1234_5678 -> next cycle write_enable=1, write_reg=5, write_data=0x1234_5678; stall stays 0.
- Load extension: issue LB reg 3 offset 2, then LHU reg 4 offset 2, then return 0x80FF_7F01 twice -> writes 0xFFFF_FFFF to reg 3 and 0x0000_80FF to reg 4; busy bits 3 and 4 set until each retires.
- Collision: mem_rvalid (LW reg 7, data 0xAAAA_0000) and alu_valid (reg 8, data 0x55) in the same cycle -> reg 7 written first, reg 8 written the next cycle; stall=1 for exactly one cycle.
- Full queue: with LOAD_DEPTH=2, issue two loads -> stall=1 with no returns; one return -> stall=0 the following cycle; a third issue while full -> wb_error=1 and entry dropped.
- Reg 0 and spurious return: LW to reg 0 returned -> write_enable stays 0 and queue empties; mem_rvalid with empty queue -> wb_error=1.
- Async reset mid-load: two loads pending, assert reset between edges -> busy_mask=0, stall=0, write_enable=0 immediately.

Source files
------------

// File: rtl/writeback_unit.sv
// Final pipeline stage: merges single-cycle ALU results with in-order load returns
// into one registered register-file write port, tracking outstanding load targets.
module writeback_unit #(
  parameter int LOAD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        load_issue,
  input  logic [4:0]  load_issue_reg,
  input  logic [2:0]  load_issue_type,
  input  logic [1:0]  load_issue_offset,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        write_enable,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [31:0] busy_mask,
  output logic        stall,
  output logic        wb_error
);
  localparam int PW = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
  localparam int CW = $clog2(LOAD_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(LOAD_DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(LOAD_DEPTH - 1);

  // Queue payload lives in plain storage; occupancy is tracked by per-entry valid bits.
  logic [4:0] q_reg_mem  [LOAD_DEPTH];
  logic [2:0] q_type_mem [LOAD_DEPTH];
  logic [1:0] q_off_mem  [LOAD_DEPTH];

  logic [LOAD_DEPTH-1:0] q_valid_reg, q_valid_next;
  logic [PW-1:0] head_reg, head_next, tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic        skid_valid_reg, skid_valid_next;
  logic [4:0]  skid_dst_reg, skid_dst_next;
  logic [31:0] skid_data_reg, skid_data_next;

  logic        we_reg, we_next;
  logic [4:0]  wr_reg, wr_next;
  logic [31:0] wd_reg, wd_next;
  logic        from_load_reg, from_load_next;
  logic        err_reg, err_next;

  logic q_full, q_empty, ld_ret, do_push;
  logic [4:0] head_dst;

  function automatic logic [31:0] extend(input logic [2:0] ltype, input logic [1:0] off,
                                         input logic [31:0] data);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = data[{off, 3'b000} +: 8];
    half_sel = off[1] ? data[31:16] : data[15:0];
    case (ltype)
      3'd1:    extend = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    extend = {24'd0, byte_sel};
      3'd3:    extend = {{16{half_sel[15]}}, half_sel};
      3'd4:    extend = {16'd0, half_sel};
      default: extend = data;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign q_full   = (count_reg == FULL_COUNT);
  assign q_empty  = (count_reg == '0);
  assign ld_ret   = mem_rvalid && !q_empty;
  assign do_push  = load_issue && !q_full;
  assign head_dst = q_reg_mem[head_reg];

  always_comb begin
    q_valid_next    = q_valid_reg;
    head_next       = head_reg;
    tail_next       = tail_reg;
    count_next      = count_reg;
    skid_valid_next = skid_valid_reg;
    skid_dst_next   = skid_dst_reg;
    skid_data_next  = skid_data_reg;
    we_next         = 1'b0;
    wr_next         = 5'd0;
    wd_next         = 32'd0;
    from_load_next  = 1'b0;
    err_next        = err_reg;

    // Source priority: load return, then skid, then live ALU result.
    if (ld_ret) begin
      we_next                = (head_dst != 5'd0);
      wr_next                = head_dst;
      wd_next                = extend(q_type_mem[head_reg], q_off_mem[head_reg], mem_rdata);
      from_load_next         = 1'b1;
      head_next              = ptr_inc(head_reg);
      q_valid_next[head_reg] = 1'b0;
      if (alu_valid) begin
        if (skid_valid_reg) begin
          err_next = 1'b1;
        end else begin
          skid_valid_next = 1'b1;
          skid_dst_next   = alu_reg;
          skid_data_next  = alu_data;
        end
      end
    end else if (skid_valid_reg) begin
      we_next         = (skid_dst_reg != 5'd0);
      wr_next         = skid_dst_reg;
      wd_next         = skid_data_reg;
      skid_valid_next = 1'b0;
      if (alu_valid) err_next = 1'b1;
    end else if (alu_valid) begin
      we_next = (alu_reg != 5'd0);
      wr_next = alu_reg;
      wd_next = alu_data;
    end

    if (mem_rvalid && q_empty) err_next = 1'b1;

    if (load_issue) begin
      if (q_full) begin
        err_next = 1'b1;
      end else begin
        q_valid_next[tail_reg] = 1'b1;
        tail_next              = ptr_inc(tail_reg);
      end
    end

    case ({do_push, ld_ret})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid_reg    <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      skid_valid_reg <= 1'b0;
      skid_dst_reg   <= 5'd0;
      skid_data_reg  <= 32'd0;
      we_reg         <= 1'b0;
      wr_reg         <= 5'd0;
      wd_reg         <= 32'd0;
      from_load_reg  <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      q_valid_reg    <= q_valid_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      skid_valid_reg <= skid_valid_next;
      skid_dst_reg   <= skid_dst_next;
      skid_data_reg  <= skid_data_next;
      we_reg         <= we_next;
      wr_reg         <= wr_next;
      wd_reg         <= wd_next;
      from_load_reg  <= from_load_next;
      err_reg        <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      q_reg_mem[tail_reg]  <= load_issue_reg;
      q_type_mem[tail_reg] <= load_issue_type;
      q_off_mem[tail_reg]  <= load_issue_offset;
    end
  end

  logic [31:0] entry_mask [LOAD_DEPTH];

  generate
    for (genvar gi = 0; gi < LOAD_DEPTH; gi++) begin : g_entry_mask
      assign entry_mask[gi] = q_valid_reg[gi] ? (32'd1 << q_reg_mem[gi]) : 32'd0;
    end
  endgenerate

  // The retiring load stays busy until the register file has actually captured it.
  always_comb begin
    busy_mask = from_load_reg ? (32'd1 << wr_reg) : 32'd0;
    for (int i = 0; i < LOAD_DEPTH; i++) busy_mask = busy_mask | entry_mask[i];
    busy_mask[0] = 1'b0;
  end

  assign stall        = skid_valid_reg || q_full;
  assign write_enable = we_reg;
  assign write_reg    = wr_reg;
  assign write_data   = wd_reg;
  assign wb_error     = err_reg;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a queue-level model predicts every cycle,
// and literal expectations pin the test-plan scenarios.
module tb_writeback_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        load_issue;
  logic [4:0]  load_issue_reg;
  logic [2:0]  load_issue_type;
  logic [1:0]  load_issue_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy_mask;
  logic        stall;
  logic        wb_error;

  writeback_unit #(.LOAD_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .load_issue(load_issue), .load_issue_reg(load_issue_reg),
    .load_issue_type(load_issue_type), .load_issue_offset(load_issue_offset),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .busy_mask(busy_mask), .stall(stall), .wb_error(wb_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { int r; int t; int o; } ent_t;
  ent_t mq[$];
  bit m_skv, m_we, m_fl, m_err;
  int m_skr, m_wr;
  logic [31:0] m_skd, m_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_ext(input int t, input int off, input logic [31:0] w);
    int b, h;
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
    case (t)
      1: return 32'(b > 127 ? b - 256 : b);
      2: return 32'(b);
      3: return 32'(h > 32767 ? h - 65536 : h);
      4: return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = m_fl ? (32'd1 << m_wr) : 32'd0;
    foreach (mq[i]) m = m | (32'd1 << mq[i].r);
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_skv = 0; m_we = 0; m_fl = 0; m_err = 0; m_skr = 0; m_wr = 0;
    m_skd = 0; m_wd = 0;
  endtask

  task automatic compare_all();
    chk("write_enable", 32'(write_enable), 32'(m_we));
    if (m_we) begin
      chk("write_reg", 32'(write_reg), 32'(m_wr));
      chk("write_data", write_data, m_wd);
    end
    chk("busy_mask", busy_mask, model_busy());
    chk("stall", 32'(stall), 32'(m_skv || mq.size() == DEPTH));
    chk("wb_error", 32'(wb_error), 32'(m_err));
  endtask

  // Advance the model with the inputs currently driven, clock once, then compare.
  task automatic step();
    int sz;
    ent_t e;
    bit n_we, n_fl;
    int n_wr;
    logic [31:0] n_wd;
    if (!reset) begin
      model_clear();
    end else begin
      sz = mq.size();
      n_we = 0; n_fl = 0; n_wr = 0; n_wd = 0;
      if (mem_rvalid && sz > 0) begin
        e = mq.pop_front();
        n_wr = e.r; n_wd = model_ext(e.t, e.o, mem_rdata); n_we = (e.r != 0); n_fl = 1;
        if (alu_valid) begin
          if (m_skv) m_err = 1;
          else begin m_skv = 1; m_skr = int'(alu_reg); m_skd = alu_data; end
        end
      end else if (m_skv) begin
        n_wr = m_skr; n_wd = m_skd; n_we = (m_skr != 0); m_skv = 0;
        if (alu_valid) m_err = 1;
      end else if (alu_valid) begin
        n_wr = int'(alu_reg); n_wd = alu_data; n_we = (alu_reg != 0);
      end
      if (mem_rvalid && sz == 0) m_err = 1;
      if (load_issue) begin
        if (sz == DEPTH) m_err = 1;
        else mq.push_back('{int'(load_issue_reg), int'(load_issue_type), int'(load_issue_offset)});
      end
      m_we = n_we; m_wr = n_wr; m_wd = n_wd; m_fl = n_fl;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    load_issue = 0; load_issue_reg = 0; load_issue_type = 0; load_issue_offset = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic issue(input int r, input int t, input int o);
    idle_in();
    load_issue = 1; load_issue_reg = 5'(r); load_issue_type = 3'(t); load_issue_offset = 2'(o);
  endtask

  task automatic ret(input logic [31:0] d);
    idle_in();
    mem_rvalid = 1; mem_rdata = d;
  endtask

  logic [31:0] words [2];

  initial begin
    words[0] = 32'h80FF_7F01;
    words[1] = 32'h7F01_80FE;
    idle_in();
    model_clear();
    reset = 0;
    #3;
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_reg", 32'(write_reg), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(wb_error), 32'd0);
    step();
    reset = 1;

    // ALU only
    alu_valid = 1; alu_reg = 5; alu_data = 32'h1234_5678;
    step();
    chk("alu_we", 32'(write_enable), 32'd1);
    chk("alu_reg", 32'(write_reg), 32'd5);
    chk("alu_data", write_data, 32'h1234_5678);
    chk("alu_stall", 32'(stall), 32'd0);
    idle_in(); step();

    // Load extension
    issue(3, 1, 2); step();
    chk("ext_busy1", busy_mask, 32'h0000_0008);
    issue(4, 4, 2); step();
    chk("ext_busy2", busy_mask, 32'h0000_0018);
    ret(32'h80FF_7F01); step();
    chk("ext_lb_data", write_data, 32'hFFFF_FFFF);
    chk("ext_lb_busy", busy_mask, 32'h0000_0018);
    ret(32'h80FF_7F01); step();
    chk("ext_lhu_reg", 32'(write_reg), 32'd4);
    chk("ext_lhu_data", write_data, 32'h0000_80FF);
    chk("ext_lhu_busy", busy_mask, 32'h0000_0010);
    idle_in(); step();
    chk("ext_busy_clear", busy_mask, 32'd0);

    // Collision of load return with ALU result
    issue(7, 0, 0); step();
    ret(32'hAAAA_0000);
    alu_valid = 1; alu_reg = 8; alu_data = 32'h55;
    step();
    chk("col_reg1", 32'(write_reg), 32'd7);
    chk("col_data1", write_data, 32'hAAAA_0000);
    chk("col_stall1", 32'(stall), 32'd1);
    idle_in(); step();
    chk("col_reg2", 32'(write_reg), 32'd8);
    chk("col_data2", write_data, 32'h55);
    chk("col_stall2", 32'(stall), 32'd0);

    // Every load type across every offset, two data patterns
    for (int t = 0; t < 6; t++) begin
      for (int o = 0; o < 4; o++) begin
        issue(((t * 4 + o) % 31) + 1, t, o); step();
        ret(words[(t + o) % 2]); step();
      end
    end
    idle_in(); step();

    // Full queue
    issue(9, 0, 0); step();
    issue(10, 0, 0); step();
    chk("full_stall", 32'(stall), 32'd1);
    issue(11, 0, 0); step();
    chk("full_err", 32'(wb_error), 32'd1);
    chk("full_drop_busy", busy_mask, 32'h0000_0600);
    ret(32'h1122_3344); step();
    chk("full_stall_fall", 32'(stall), 32'd0);
    issue(12, 0, 0); step();

    // Async reset between edges with two loads pending
    #3;
    reset = 0;
    #1;
    chk("arst_busy", busy_mask, 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_we", 32'(write_enable), 32'd0);
    chk("arst_err", 32'(wb_error), 32'd0);
    idle_in(); step();
    reset = 1;

    // Register 0 load, then a spurious return
    issue(0, 0, 0); step();
    ret(32'hDEAD_BEEF); step();
    chk("r0_we", 32'(write_enable), 32'd0);
    idle_in(); step();
    chk("r0_busy", busy_mask, 32'd0);
    chk("r0_err", 32'(wb_error), 32'd0);
    ret(32'h0BAD_F00D); step();
    chk("spur_err", 32'(wb_error), 32'd1);
    chk("spur_we", 32'(write_enable), 32'd0);
    idle_in(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
